// File: rtl/timer_pkg.sv
// Shared definitions for the timer display path: BCD digit constants, the
// converter FSM state type and the decimal-range helper.
package timer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_e;

    // Largest value representable with the given number of decimal digits.
    function automatic int unsigned DEC_MAX(input int unsigned digits);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import timer_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    output logic [BCD_W-1:0] digit_out
);

    assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter, one bit per clock.
// Optional saturation on out-of-range input: define BCD_OVERFLOW_SAT_EN.
module bin_to_bcd_seq
    import timer_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                      clk_50MHz,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic                      overflow
);

    // Handshake: start is only looked at in IDLE and captures bin_in on that
    // edge; busy stays high for the BIN_W shift cycles, then done pulses for
    // one cycle with bcd_out updated. A start seen during that done cycle is
    // accepted, while a start during busy is dropped.

    localparam int W = BCD_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    conv_state_e        state_q, state_d;
    logic [BIN_W-1:0]   bin_reg;
    logic [W-1:0]       bcd_acc;
    logic [W-1:0]       bcd_adj;
    logic [W-1:0]       shifted_acc;
    logic [W-1:0]       result;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               last;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_add3 u_add3 (
            .digit_in  (bcd_acc[k*BCD_W +: BCD_W]),
            .digit_out (bcd_adj[k*BCD_W +: BCD_W])
        );
    end

    // Top bit of the adjusted accumulator falls off here: result is mod 10^DIGITS.
    assign shifted_acc = {bcd_adj[W-2:0], bin_reg[BIN_W-1]};

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            bin_reg <= '0;
            bcd_acc <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                bin_reg <= bin_in;
                bcd_acc <= '0;
                cnt     <= '0;
                busy    <= 1'b1;
            end else if (state_q == SHIFT) begin
                bcd_acc <= shifted_acc;
                bin_reg <= bin_reg << 1;
                cnt     <= cnt + 1'b1;
                if (last) begin
                    bcd_out <= result;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
            end
        end
    end

`ifdef BCD_OVERFLOW_SAT_EN
    localparam int unsigned DEC_MAX_V = DEC_MAX(DIGITS);
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic ovf_flag;
    logic overflow_q;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            ovf_flag   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (load) begin
                ovf_flag <= (32'(bin_in) > DEC_MAX_V);
            end
            if (last) begin
                overflow_q <= ovf_flag;
            end
        end
    end

    assign result   = ovf_flag ? ALL_NINES : shifted_acc;
    assign overflow = overflow_q;
`else
    assign result   = shifted_acc;
    assign overflow = 1'b0;
`endif

endmodule
